// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, arbiter state encoding and command record
package dmem_arbiter_pkg;
  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  localparam int Func3Width = 3;
  localparam int ArbStateWidth = 2;
  typedef enum logic [ArbStateWidth-1:0] {
    ArbIdle   = 2'd0,
    ArbAccess = 2'd1,
    ArbResp   = 2'd2
  } arb_state_t;
  typedef struct packed {
    logic                  we;
    logic [Func3Width-1:0] func3;
    logic [AddrWidth-1:0]  addr;
    logic [DataWidth-1:0]  wdata;
    logic                  win;
  } arb_cmd_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/grant/response bundle
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;
  logic                  req;
  logic                  we;
  logic [Func3Width-1:0] func3;
  logic [AddrWidth-1:0]  addr;
  logic [DataWidth-1:0]  wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DataWidth-1:0]  rdata;
  modport master (output req, we, func3, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, func3, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// arb_rr_pick: two-way round-robin pick; on a tie the port other than last wins
module arb_rr_pick (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_win
);
  assign o_win = (i_req0 & i_req1) ? ~i_last : i_req1;
  assign o_gnt = {i_req1 & o_win, i_req0 & ~o_win};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single data-memory port between MEM stage and debug loader
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  dmem_arbiter_if.slave         io_p0,
  dmem_arbiter_if.slave         io_p1,
  output logic                  o_stall0,
  output logic                  o_busy,
  output logic                  o_mem_we,
  output logic [Func3Width-1:0] o_mem_func3,
  output logic [AddrWidth-1:0]  o_mem_addr,
  output logic [DataWidth-1:0]  o_mem_wdata,
  input  logic [DataWidth-1:0]  i_mem_rdata
);
  arb_state_t           r_state;
  logic                 r_last;
  arb_cmd_t             r_cmd;
  logic [DataWidth-1:0] r_resp;
  logic                 w_acc;
  logic                 w_resp;
  logic                 w_gp;
  logic                 w_last;
  logic                 w_win;
  logic                 w_any;
  logic [1:0]           w_pick;
  logic                 w_gnt0;
  logic                 w_rv0;
  logic                 w_rv1;
  arb_cmd_t             w_cmd;
  assign w_acc = r_state == ArbAccess;
  assign w_resp = (r_state == ArbResp) & ~reset;
  assign w_gp = ~reset & ~w_acc;
  // the port being answered this cycle already counts as last for the concurrent grant
  assign w_last = (r_state == ArbResp) ? r_cmd.win : r_last;
  arb_rr_pick u_pick (
    .i_req0 (io_p0.req),
    .i_req1 (io_p1.req),
    .i_last (w_last),
    .o_gnt  (w_pick),
    .o_win  (w_win)
  );
  assign w_any = |w_pick;
  assign w_gnt0 = w_gp & w_pick[0];
  assign io_p0.gnt = w_gnt0;
  assign io_p1.gnt = w_gp & w_pick[1];
  assign w_rv0 = w_resp & ~r_cmd.win;
  assign w_rv1 = w_resp & r_cmd.win;
  assign io_p0.rvalid = w_rv0;
  assign io_p1.rvalid = w_rv1;
  assign io_p0.rdata = w_rv0 ? r_resp : '0;
  assign io_p1.rdata = w_rv1 ? r_resp : '0;
  assign o_stall0 = io_p0.req & ~w_gnt0;
  assign o_busy = r_state != ArbIdle;
  assign o_mem_we = w_acc & r_cmd.we & ~reset;
  assign o_mem_func3 = w_acc ? r_cmd.func3 : '0;
  assign o_mem_addr = w_acc ? r_cmd.addr : '0;
  assign o_mem_wdata = w_acc ? r_cmd.wdata : '0;
  // select the winning requester's fields for latching
  always_comb begin
    w_cmd = w_win ? {io_p1.we, io_p1.func3, io_p1.addr, io_p1.wdata, 1'b1}
                  : {io_p0.we, io_p0.func3, io_p0.addr, io_p0.wdata, 1'b0};
  end
  // arbiter state, command latch and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ArbIdle;
      r_last <= 1'b1;
      r_cmd <= '0;
      r_resp <= '0;
    end else if (w_acc) begin
      r_resp <= r_cmd.we ? '0 : i_mem_rdata;
      r_state <= ArbResp;
    end else begin
      if (r_state == ArbResp) r_last <= r_cmd.win;
      if (w_any) begin
        r_cmd <= w_cmd;
        r_state <= ArbAccess;
      end else begin
        r_state <= ArbIdle;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant, access, response, alternation and reset behaviour
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  logic clk;
  logic reset;
  logic stall0;
  logic busy;
  logic mem_we;
  logic [Func3Width-1:0] mem_func3;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_rdata;
  logic [31:0] mem [64];
  int total = 0;
  int bad = 0;
  dmem_arbiter_if p0 ();
  dmem_arbiter_if p1 ();
  dmem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .io_p0       (p0),
    .io_p1       (p1),
    .o_stall0    (stall0),
    .o_busy      (busy),
    .o_mem_we    (mem_we),
    .o_mem_func3 (mem_func3),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[12] = 32'h55555555;
    mem[16] = 32'hCAFEF00D;
    reset = 1'b1;
    p0.req = 0; p0.we = 0; p0.func3 = 0; p0.addr = 0; p0.wdata = 0;
    p1.req = 0; p1.we = 0; p1.func3 = 0; p1.addr = 0; p1.wdata = 0;
    repeat (3) nxt();
    #1;
    chk("rst_ctl", {busy, p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, mem_we, stall0}, 0);
    chk("rst_addr", mem_addr, 0);
    nxt();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      #1;
      chk("idle_ctl", {busy, p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, mem_we, stall0}, 0);
      chk("idle_bus", mem_addr | mem_wdata | p0.rdata | p1.rdata | 32'(mem_func3), 0);
    end
    nxt();
    p0.req = 1; p0.we = 0; p0.func3 = 3'b010; p0.addr = 32'h10;
    #1;
    chk("ld0_gnt", {p0.gnt, p1.gnt, stall0}, 3'b100);
    nxt();
    p0.req = 0;
    #1;
    chk("ld0_acc", {busy, mem_we, p0.gnt}, 3'b100);
    chk("ld0_addr", mem_addr, 32'h10);
    chk("ld0_f3", 32'(mem_func3), 2);
    nxt();
    #1;
    chk("ld0_rv", {p0.rvalid, p1.rvalid}, 2'b10);
    chk("ld0_rd", p0.rdata, 32'hDEADBEEF);
    chk("ld0_rd1", p1.rdata, 0);
    nxt();
    #1;
    chk("ld0_done", {busy, p0.rvalid}, 0);
    nxt();
    p1.req = 1; p1.we = 1; p1.func3 = 3'b010; p1.addr = 32'h20; p1.wdata = 32'h12345678;
    #1;
    chk("st1_gnt", {p0.gnt, p1.gnt}, 2'b01);
    nxt();
    p1.req = 0;
    #1;
    chk("st1_we", mem_we, 1);
    chk("st1_addr", mem_addr, 32'h20);
    chk("st1_wd", mem_wdata, 32'h12345678);
    chk("st1_f3", 32'(mem_func3), 2);
    nxt();
    p0.req = 1; p0.we = 0; p0.addr = 32'h20;
    #1;
    chk("st1_rv", {p1.rvalid, p0.rvalid, mem_we}, 3'b100);
    chk("st1_rd", p1.rdata, 0);
    chk("b2b_gnt", {p0.gnt, p1.gnt}, 2'b10);
    nxt();
    p0.req = 0;
    #1;
    chk("ld20_acc", {mem_we, mem_addr}, {1'b0, 32'h20});
    nxt();
    #1;
    chk("ld20_rv", p0.rvalid, 1);
    chk("ld20_rd", p0.rdata, 32'h12345678);
    nxt();
    #1;
    chk("ld20_idle", busy, 0);
    nxt();
    p1.req = 1; p1.we = 0; p1.addr = 32'h40; p1.wdata = 0;
    #1;
    chk("chg_gnt", p1.gnt, 1);
    nxt();
    p1.req = 0; p1.addr = 32'h80;
    #1;
    chk("chg_addr", mem_addr, 32'h40);
    nxt();
    #1;
    chk("chg_rd", {p1.rvalid, p1.rdata}, {1'b1, 32'hCAFEF00D});
    nxt();
    p0.req = 1; p0.we = 1; p0.addr = 32'h30; p0.wdata = 32'hAAAAAAAA;
    #1;
    chk("rsta_gnt", p0.gnt, 1);
    nxt();
    p0.req = 0; reset = 1;
    #1;
    chk("rsta_we", mem_we, 0);
    chk("rsta_rv", {p0.rvalid, p1.rvalid}, 0);
    nxt();
    reset = 0;
    #1;
    chk("rsta_busy", {busy, p0.rvalid, p1.rvalid}, 0);
    chk("rsta_mem", mem[12], 32'h55555555);
    nxt();
    p0.req = 1; p0.we = 0; p0.addr = 32'h30;
    #1;
    chk("ld30_gnt", p0.gnt, 1);
    nxt();
    p0.req = 0;
    #1;
    nxt();
    #1;
    chk("ld30_rd", {p0.rvalid, p0.rdata}, {1'b1, 32'h55555555});
    nxt();
    p1.req = 1; p1.we = 0; p1.addr = 32'h10;
    #1;
    chk("rstr_gnt", p1.gnt, 1);
    nxt();
    p1.req = 0;
    #1;
    nxt();
    reset = 1;
    #1;
    chk("rstr_rv", {p1.rvalid, p0.rvalid}, 0);
    chk("rstr_rd", p1.rdata, 0);
    nxt();
    p0.req = 1; p0.we = 0; p0.addr = 32'h10;
    p1.req = 1; p1.we = 0; p1.addr = 32'h40;
    #1;
    chk("rst_nognt", {p0.gnt, p1.gnt}, 0);
    nxt();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nxt();
      #1;
      chk("alt_gnt", {p0.gnt, p1.gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_stall", stall0, (i % 2 == 1) ? 1 : 0);
      chk("alt_rv", {p0.rvalid, p1.rvalid}, (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b10 : 2'b01));
      chk("alt_rd0", p0.rdata, (i > 0 && i % 2 == 1) ? 32'hDEADBEEF : 0);
      nxt();
      #1;
      chk("alt_gap", {p0.gnt, p1.gnt, stall0}, 3'b001);
      chk("alt_addr", mem_addr, (i % 2 == 0) ? 32'h10 : 32'h40);
    end
    nxt();
    p0.req = 0; p1.req = 0;
    #1;
    chk("alt_last", {p1.rvalid, p0.gnt, p1.gnt}, 3'b100);
    chk("alt_rd1", p1.rdata, 32'hCAFEF00D);
    nxt();
    #1;
    chk("end_idle", {busy, mem_we, stall0}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single data-memory port (DataMem: write enable, func3, address, write data, combinational read data) between the pipeline MEM-stage load/store path (port 0) and the debug/program-loader path (port 1). It accepts one request per grant, latches the command, performs exactly one memory access cycle and returns a one-cycle response. It sits between the Controller/MEM stage and DataMem and produces the MEM-stage stall.

## Interface
- AddrWidth, 32, address width
- DataWidth, 32, data width
- Func3Width, 3, access size/sign code passed unchanged to memory

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request, held until gnt
- we0 / we1  in  1  1 = store, 0 = load
- func3_0 / func3_1  in  Func3Width  access size code
- addr0 / addr1  in  AddrWidth  byte address
- wdata0 / wdata1  in  DataWidth  store data
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  one-cycle response strobe
- rdata0 / rdata1  out  DataWidth  load data (0 for stores), valid with rvalid
- stall0  out  1  req0 & ~gnt0, to pipeline hazard logic
- busy  out  1  state != ArbIdle
- mem_we  out  1  to DataMem write enable
- mem_func3  out  Func3Width  to DataMem
- mem_addr  out  AddrWidth  to DataMem
- mem_wdata  out  DataWidth  to DataMem
- mem_rdata  in  DataWidth  from DataMem, combinational on mem_addr

## Operation
- States: ArbIdle, ArbAccess, ArbResp.
- Grant point: ArbIdle or ArbResp with any req. Winner: sole requester; if both, port != last. Assert gnt of winner, latch we/func3/addr/wdata/winner into command registers, go to ArbAccess. No req: go/stay ArbIdle.
- ArbAccess: drive mem_* from command registers; mem_we = cmd_we & ~reset for this cycle only; capture mem_rdata (or 0 for stores) into response register; go to ArbResp.
- ArbResp: rvalid of cmd winner = 1 with response data; last <= winner; grant point as above.
- Outside ArbAccess: mem_we, mem_func3, mem_addr, mem_wdata all 0.
- rdata of the non-responding port and of both ports when rvalid = 0: 0.
- Requester fields after gnt are ignored; req held low after gnt means no further access.
- Never two grants in one cycle; never gnt to a port without req.

## Timing
- Reset: state ArbIdle, last = 1 (port 0 wins first tie), all outputs 0, command/response registers 0.
- req in cycle N (state ArbIdle): gnt in N, memory access in N+1, rvalid in N+2.
- Back-to-back: next grant in N+2 (concurrent with rvalid), access N+3; peak throughput 1 access per 2 cycles.
- Both requesting continuously: strict alternation 0,1,0,1; max wait for a holding requester is one foreign access (4 cycles from req to gnt).
- Reset during ArbAccess: mem_we forced 0 that cycle, no rvalid, state ArbIdle next cycle.
- Reset during ArbResp: rvalid suppressed, last reset to 1.
- Store then load to same address from different ports: load sees stored data (write committed in earlier access cycle).

## Structure
- Shared Defines.v: ArbStateWidth (2), ArbIdle = 0, ArbAccess = 1, ArbResp = 2; reuse AddrWidth, DataWidth, Func3Width.
- One sub-module is natural: arb_rr_pick (req0, req1, last -> grant vector, winner index), purely combinational, reused by future instruction/data port sharing.
- All state in a single clocked process; mem_* and gnt derived combinationally from state and registers.

## Test plan
- Port 0 load, func3 = 010, addr 0x10, memory holds 0xDEADBEEF -> gnt0 at N, mem_addr = 0x10 at N+1, rvalid0 = 1 with rdata0 = 0xDEADBEEF at N+2, rvalid1 = 0.
- Port 1 store addr 0x20 data 0x12345678 func3 = 010 -> mem_we = 1 exactly at N+1 with those values, rvalid1 at N+2 with rdata1 = 0; later port 0 load of 0x20 returns 0x12345678.
- Both req held from reset release for 8 accesses -> grant order 0,1,0,1,0,1,0,1, grants 2 cycles apart, stall0 high on each port-1 grant cycle.
- Port 1 changes addr from 0x40 to 0x80 in the cycle after gnt1 -> mem_addr = 0x40.
- Reset asserted in the ArbAccess cycle of a store to 0x30 -> mem_we = 0, no rvalid, memory at 0x30 unchanged, busy = 0 next cycle.
- No requests for 10 cycles -> all outputs 0, busy = 0.
